// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause field positions,
// the exception vector and ExcCode values used by exception_ctrl.
package cp0_regfile_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_BEV   = 22;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_HW_LO  = 10;
    localparam int CAUSE_TI     = 30;
    localparam int CAUSE_BD     = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    // Status as seen by MFC0; BEV is hard-wired to 1.
    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        logic [31:0] s;
        s = 32'h0000_0000;
        s[STATUS_BEV]         = 1'b1;
        s[STATUS_IM_LO +: 8]  = im;
        s[STATUS_EXL]         = exl;
        s[STATUS_IE]          = ie;
        return s;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic       ti,
                                               input logic [5:0] hw,
                                               input logic [1:0] sw,
                                               input logic [4:0] exc);
        logic [31:0] c;
        c = 32'h0000_0000;
        c[CAUSE_BD]           = bd;
        c[CAUSE_TI]           = ti;
        c[CAUSE_HW_LO +: 6]   = hw;
        c[CAUSE_IP_LO +: 2]   = sw;
        c[CAUSE_EXC_LO +: 5]  = exc;
        return c;
    endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// CP0 Count/Compare timer: divided free-running counter and sticky timer
// interrupt flag.
module cp0_regfile_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        phase_r;
    logic        ti_r;
    logic        tick_s;
    logic        match_s;

    // Increment enable and timer match, both from registered state.
    always_comb begin
        tick_s  = (COUNT_DIV == 1) ? 1'b1 : phase_r;
        match_s = (count_r == compare_r) && (compare_r != 32'h0000_0000);
    end

    // Timer state; a Count load restarts the divider, a Compare write beats a match.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_r   <= 32'h0000_0000;
            compare_r <= 32'h0000_0000;
            phase_r   <= 1'b0;
            ti_r      <= 1'b0;
        end else begin
            if (count_we) begin
                count_r <= wdata;
                phase_r <= 1'b0;
            end else begin
                phase_r <= ~tick_s;
                if (tick_s) begin
                    count_r <= count_r + 32'd1;
                end
            end
            if (compare_we) begin
                compare_r <= wdata;
                ti_r      <= 1'b0;
            end else if (match_s) begin
                ti_r <= 1'b1;
            end
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 architectural state: Status/Cause/EPC/BadVAddr plus the timer, MFC0 read
// port, exception/ERET commit and the PC redirect.
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        eret,
    input  logic        is_exception,
    input  logic        is_bd,
    input  logic [4:0]  excep_code,
    input  logic [31:0] excep_pc,
    input  logic        we_badvaddr,
    input  logic [31:0] badvaddr,
    input  logic [5:0]  ext_int,
    output logic        is_ie,
    output logic        is_exl,
    output logic [7:0]  int_mask,
    output logic [1:0]  soft_int,
    output logic [5:0]  hardware_int,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic        ie_r;
    logic        exl_r;
    logic [7:0]  im_r;
    logic [1:0]  soft_r;
    logic        bd_r;
    logic [4:0]  exc_r;
    logic [31:0] epc_r;
    logic [31:0] badvaddr_r;

    logic        eret_s;
    logic        mtc0_s;
    logic        count_we_s;
    logic        compare_we_s;
    logic [31:0] count_s;
    logic [31:0] compare_s;
    logic        ti_s;
    logic [5:0]  hw_int_s;

    // Commit priority: exception, then ERET, then MTC0.
    always_comb begin
        eret_s       = eret & ~is_exception;
        mtc0_s       = mtc0_we & ~is_exception & ~eret;
        count_we_s   = mtc0_s && (cp0_waddr == CP0_COUNT);
        compare_we_s = mtc0_s && (cp0_waddr == CP0_COMPARE);
        hw_int_s     = {ext_int[5] | ti_s, ext_int[4:0]};
    end

    cp0_regfile_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wdata      (cp0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Status/Cause/EPC/BadVAddr state; a nested exception keeps EPC and BD.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ie_r       <= 1'b0;
            exl_r      <= 1'b0;
            im_r       <= 8'h00;
            soft_r     <= 2'b00;
            bd_r       <= 1'b0;
            exc_r      <= 5'h00;
            epc_r      <= 32'h0000_0000;
            badvaddr_r <= 32'h0000_0000;
        end else if (is_exception) begin
            exc_r <= excep_code;
            exl_r <= 1'b1;
            if (!exl_r) begin
                epc_r <= excep_pc;
                bd_r  <= is_bd;
            end
            if (we_badvaddr) begin
                badvaddr_r <= badvaddr;
            end
        end else if (eret_s) begin
            exl_r <= 1'b0;
        end else if (mtc0_s) begin
            case (cp0_waddr)
                CP0_STATUS: begin
                    im_r  <= cp0_wdata[STATUS_IM_LO +: 8];
                    exl_r <= cp0_wdata[STATUS_EXL];
                    ie_r  <= cp0_wdata[STATUS_IE];
                end
                CP0_CAUSE: soft_r <= cp0_wdata[CAUSE_IP_LO +: 2];
                CP0_EPC:   epc_r  <= cp0_wdata;
                default: ;
            endcase
        end
    end

    // MFC0 read mux; returns pre-write values and zero for unimplemented regs.
    always_comb begin
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_r;
            CP0_COUNT:    cp0_rdata = count_s;
            CP0_COMPARE:  cp0_rdata = compare_s;
            CP0_STATUS:   cp0_rdata = pack_status(im_r, exl_r, ie_r);
            CP0_CAUSE:    cp0_rdata = pack_cause(bd_r, ti_s, hw_int_s, soft_r, exc_r);
            CP0_EPC:      cp0_rdata = epc_r;
            default:      cp0_rdata = 32'h0000_0000;
        endcase
    end

    // Zero-latency redirect; ERET returns to the registered EPC.
    always_comb begin
        redirect = is_exception | eret;
        if (is_exception) begin
            redirect_pc = EXC_VECTOR;
        end else if (eret) begin
            redirect_pc = epc_r;
        end else begin
            redirect_pc = 32'h0000_0000;
        end
    end

    assign is_ie        = ie_r;
    assign is_exl       = exl_r;
    assign int_mask     = im_r;
    assign soft_int     = soft_r;
    assign hardware_int = hw_int_s;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed + randomized bench for cp0_regfile against a field-level model.
module tb_cp0_regfile;

    localparam int CDIV = 2;

    logic        clk;
    logic        resetn;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        eret;
    logic        is_exception;
    logic        is_bd;
    logic [4:0]  excep_code;
    logic [31:0] excep_pc;
    logic        we_badvaddr;
    logic [31:0] badvaddr;
    logic [5:0]  ext_int;
    logic        is_ie;
    logic        is_exl;
    logic [7:0]  int_mask;
    logic [1:0]  soft_int;
    logic [5:0]  hardware_int;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: architectural fields, Count as base + elapsed cycles.
    logic        m_ie, m_exl, m_bd, m_ti;
    logic [7:0]  m_im;
    logic [1:0]  m_soft;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badv, m_compare, m_cnt_base;
    int          m_cyc;

    cp0_regfile #(.EXC_VECTOR(32'hBFC0_0380), .COUNT_DIV(CDIV)) dut (
        .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .eret(eret), .is_exception(is_exception), .is_bd(is_bd),
        .excep_code(excep_code), .excep_pc(excep_pc), .we_badvaddr(we_badvaddr),
        .badvaddr(badvaddr), .ext_int(ext_int), .is_ie(is_ie), .is_exl(is_exl),
        .int_mask(int_mask), .soft_int(soft_int), .hardware_int(hardware_int),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_cyc / CDIV);
    endfunction

    function automatic logic [5:0] m_hw();
        return {ext_int[5] | m_ti, ext_int[4:0]};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return (32'h1 << 22) | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_hw()) << 10)
                          | (32'(m_soft) << 8) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_rpc();
        if (is_exception) return 32'hBFC0_0380;
        if (eret) return m_epc;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_ie = 1'b0; m_exl = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
        m_im = 8'h00; m_soft = 2'b00; m_exc = 5'h00;
        m_epc = 32'h0; m_badv = 32'h0; m_compare = 32'h0; m_cnt_base = 32'h0;
        m_cyc = 0;
    endtask

    task automatic model_update();
        logic mt;
        mt = mtc0_we && !is_exception && !eret;
        if (mt && cp0_waddr == 5'd11) m_ti = 1'b0;
        else if (m_count() == m_compare && m_compare != 32'h0) m_ti = 1'b1;
        if (mt && cp0_waddr == 5'd9) begin
            m_cnt_base = cp0_wdata;
            m_cyc = 0;
        end else begin
            m_cyc++;
        end
        if (is_exception) begin
            m_exc = excep_code;
            if (!m_exl) begin
                m_epc = excep_pc;
                m_bd  = is_bd;
            end
            m_exl = 1'b1;
            if (we_badvaddr) m_badv = badvaddr;
        end else if (eret) begin
            m_exl = 1'b0;
        end else if (mt) begin
            case (cp0_waddr)
                5'd11: m_compare = cp0_wdata;
                5'd12: begin
                    m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
                end
                5'd13: m_soft = cp0_wdata[9:8];
                5'd14: m_epc = cp0_wdata;
                default: ;
            endcase
        end
    endtask

    task automatic idle();
        mtc0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'h0;
        eret = 1'b0; is_exception = 1'b0; is_bd = 1'b0; excep_code = 5'h0;
        excep_pc = 32'h0; we_badvaddr = 1'b0; badvaddr = 32'h0; ext_int = 6'h0;
    endtask

    // One clock: combinational checks, model advance, registered checks.
    task automatic step();
        #1;
        chk("rdata", cp0_rdata, exp_rd(cp0_raddr));
        chk("redirect", 32'(redirect), 32'(is_exception | eret));
        chk("redirect_pc", redirect_pc, exp_rpc());
        if (!resetn) model_reset();
        else model_update();
        @(posedge clk);
        #1;
        chk("is_ie", 32'(is_ie), 32'(m_ie));
        chk("is_exl", 32'(is_exl), 32'(m_exl));
        chk("int_mask", 32'(int_mask), 32'(m_im));
        chk("soft_int", 32'(soft_int), 32'(m_soft));
        chk("hardware_int", 32'(hardware_int), 32'(m_hw()));
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        mtc0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
        step();
        idle();
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        chk(tag, cp0_rdata, exp);
    endtask

    initial begin
        logic [4:0] addrs [8];
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd5};
        idle();
        cp0_raddr = 5'd0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        resetn = 1'b1;

        // Reset values
        rd_chk("rst_status", 5'd12, 32'h0040_0000);
        rd_chk("rst_count", 5'd9, 32'h0);
        rd_chk("rst_cause", 5'd13, 32'h0);
        rd_chk("rst_epc", 5'd14, 32'h0);
        chk("rst_redirect", 32'(redirect), 32'h0);

        // Status write, then first exception
        mtc0(5'd12, 32'h0000_FF01);
        chk("ie_set", 32'(is_ie), 32'h1);
        chk("im_set", 32'(int_mask), 32'hFF);
        is_exception = 1'b1; excep_code = 5'h0C; excep_pc = 32'hBFC0_1234; is_bd = 1'b1;
        #1;
        chk("exc_vector", redirect_pc, 32'hBFC0_0380);
        step();
        idle();
        rd_chk("epc_first", 5'd14, 32'hBFC0_1234);
        rd_chk("cause_first", 5'd13, 32'h8000_0030);
        chk("exl_set", 32'(is_exl), 32'h1);

        // Nested exception keeps EPC/BD, updates ExcCode
        is_exception = 1'b1; excep_code = 5'h08; excep_pc = 32'h8000_0000; is_bd = 1'b0;
        step();
        idle();
        rd_chk("epc_nested", 5'd14, 32'hBFC0_1234);
        rd_chk("cause_nested", 5'd13, 32'h8000_0020);
        eret = 1'b1;
        #1;
        chk("eret_pc", redirect_pc, 32'hBFC0_1234);
        step();
        idle();
        chk("exl_clr", 32'(is_exl), 32'h0);

        // Timer match at Count == Compare == 5
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        repeat (10) step();
        rd_chk("count_5", 5'd9, 32'd5);
        chk("ti_not_yet", 32'(hardware_int[5]), 32'h0);
        step();
        chk("ti_set", 32'(hardware_int[5]), 32'h1);
        mtc0(5'd11, 32'd100);
        chk("ti_clr", 32'(hardware_int[5]), 32'h0);

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd_chk("count_max", 5'd9, 32'hFFFF_FFFF);
        step();
        step();
        rd_chk("count_wrap", 5'd9, 32'h0);
        chk("no_ti_wrap", 32'(hardware_int[5]), 32'h0);

        // Exception beats ERET and MTC0 EPC in the same cycle
        is_exception = 1'b1; eret = 1'b1; excep_pc = 32'h1234_5678; excep_code = 5'h04;
        mtc0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h1;
        #1;
        chk("prio_pc", redirect_pc, 32'hBFC0_0380);
        step();
        idle();
        rd_chk("prio_epc", 5'd14, 32'h1234_5678);
        chk("prio_exl", 32'(is_exl), 32'h1);

        // Reset in the middle of an exception
        mtc0(5'd11, 32'd3);
        is_exception = 1'b1; we_badvaddr = 1'b1; badvaddr = 32'hDEAD_BEEF;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        idle();
        rd_chk("midrst_status", 5'd12, 32'h0040_0000);
        rd_chk("midrst_badv", 5'd8, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            idle();
            if ($urandom_range(0, 99) < 6) begin
                is_exception = 1'b1;
                excep_code   = 5'($urandom_range(0, 31));
                excep_pc     = $urandom;
                is_bd        = 1'($urandom_range(0, 1));
                we_badvaddr  = 1'($urandom_range(0, 1));
                badvaddr     = $urandom;
            end
            if ($urandom_range(0, 99) < 8) eret = 1'b1;
            if ($urandom_range(0, 99) < 40) begin
                mtc0_we   = 1'b1;
                cp0_waddr = addrs[$urandom_range(0, 7)];
                cp0_wdata = $urandom;
                if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 1)
                    cp0_wdata = m_count() + 32'($urandom_range(1, 8));
            end
            if ($urandom_range(0, 3) == 0) ext_int = 6'($urandom_range(0, 63));
            cp0_raddr = addrs[$urandom_range(0, 7)];
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
